// File: rtl/alu_wide_seq_pkg.sv
// Shared types and operation codes for the two-pass wide ALU.
// The FSM walks IDLE -> LO -> HI -> DONE once per request.
package alu_wide_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_LO   = 2'b01,
      ST_HI   = 2'b10,
      ST_DONE = 2'b11
   } state_t;

   // M=1 selects arithmetic, M=0 selects bitwise logic
   localparam logic [3:0] S_ADD = 4'b1001;
   localparam logic       M_ADD = 1'b1;
   localparam logic [3:0] S_SUB = 4'b0011;
   localparam logic       M_SUB = 1'b1;
   localparam logic [3:0] S_AND = 4'b1000;
   localparam logic       M_AND = 1'b0;

   localparam logic [3:0] S_INC = 4'b0000;
   localparam logic [3:0] S_DEC = 4'b1111;
   localparam logic [3:0] S_OR  = 4'b1110;
   localparam logic [3:0] S_XOR = 4'b0110;
   localparam logic [3:0] S_NOTA = 4'b0000;
   localparam logic [3:0] S_PASSB = 4'b1010;
   localparam logic [3:0] S_PASSA = 4'b1111;

endpackage

// File: rtl/alu_wide_seq_core.sv
// Combinational n-bit ALU slice. Subtraction is A + ~B + Cin, so Cin=1 and
// C=1 both mean "no borrow"; logic operations report C=V=0.
module alu_core
   import alu_wide_seq_pkg::*;
#(
   parameter int n = 32
) (
   input  logic [n-1:0] i_A,
   input  logic [n-1:0] i_B,
   input  logic [3:0]   i_S,
   input  logic         i_M,
   input  logic         i_Cin,
   output logic [n-1:0] o_DO,
   output logic         o_C,
   output logic         o_V,
   output logic         o_Z
);

   logic [n-1:0] w_opB;
   logic [n:0]   w_sum;

   always_comb begin
      w_opB = '0;
      w_sum = '0;
      o_DO  = '0;
      o_C   = 1'b0;
      o_V   = 1'b0;
      if (i_M) begin
         case (i_S)
            S_ADD:   w_opB = i_B;
            S_SUB:   w_opB = ~i_B;
            S_INC:   w_opB = '0;
            S_DEC:   w_opB = '1;
            default: w_opB = i_B;
         endcase
         w_sum = {1'b0, i_A} + {1'b0, w_opB} + {{n{1'b0}}, i_Cin};
         o_DO  = w_sum[n-1:0];
         o_C   = w_sum[n];
         // Signed overflow: like-signed operands produced a differently-signed sum
         o_V   = (i_A[n-1] == w_opB[n-1]) && (w_sum[n-1] != i_A[n-1]);
      end else begin
         case (i_S)
            S_AND:   o_DO = i_A & i_B;
            S_OR:    o_DO = i_A | i_B;
            S_XOR:   o_DO = i_A ^ i_B;
            S_NOTA:  o_DO = ~i_A;
            S_PASSB: o_DO = i_B;
            S_PASSA: o_DO = i_A;
            default: o_DO = i_A & i_B;
         endcase
      end
   end

   assign o_Z = (o_DO == '0);

endmodule

// File: rtl/alu_wide_seq.sv
// 2N-bit ALU built from one N-bit alu_core used twice: low half, then high
// half with the low carry chained in. Valid/ready on both sides.
module alu_wide_seq
   import alu_wide_seq_pkg::*;
#(
   parameter int N = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [2*N-1:0] in_opA,
   input  logic [2*N-1:0] in_opB,
   input  logic [3:0]     in_S,
   input  logic           in_M,
   input  logic           in_Cin,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*N-1:0] out_DO,
   output logic           out_C,
   output logic           out_V,
   output logic           out_N,
   output logic           out_Z
);

   state_t r_state;
   state_t w_nextState;

   logic [2*N-1:0] r_opA;
   logic [2*N-1:0] r_opB;
   logic [3:0]     r_S;
   logic           r_M;
   logic           r_Cin;
   logic [N-1:0]   r_doLo;
   logic           r_carryLo;
   logic           r_zeroLo;
   logic [2*N-1:0] r_outDO;
   logic           r_outC;
   logic           r_outV;
   logic           r_outN;
   logic           r_outZ;

   logic [N-1:0]   w_coreA;
   logic [N-1:0]   w_coreB;
   logic           w_coreCin;
   logic [N-1:0]   w_coreDO;
   logic           w_coreC;
   logic           w_coreV;
   logic           w_coreZ;
   logic           w_accept;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         ST_IDLE: if (in_valid) w_nextState = ST_LO;
         ST_LO:   w_nextState = ST_HI;
         ST_HI:   w_nextState = ST_DONE;
         ST_DONE: if (out_ready) w_nextState = ST_IDLE;
         default: w_nextState = ST_IDLE;
      endcase
   end

   // In the high pass only arithmetic chains the low-half carry
   always_comb begin
      in_ready  = (r_state == ST_IDLE);
      out_valid = (r_state == ST_DONE);
      w_accept  = in_valid && (r_state == ST_IDLE);
      w_coreA   = r_opA[N-1:0];
      w_coreB   = r_opB[N-1:0];
      w_coreCin = r_Cin;
      if (r_state == ST_HI) begin
         w_coreA   = r_opA[2*N-1:N];
         w_coreB   = r_opB[2*N-1:N];
         w_coreCin = r_M ? r_carryLo : r_Cin;
      end
   end

   alu_core #(.n(N)) u_core (
      .i_A   (w_coreA),
      .i_B   (w_coreB),
      .i_S   (r_S),
      .i_M   (r_M),
      .i_Cin (w_coreCin),
      .o_DO  (w_coreDO),
      .o_C   (w_coreC),
      .o_V   (w_coreV),
      .o_Z   (w_coreZ)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_opA     <= '0;
         r_opB     <= '0;
         r_S       <= '0;
         r_M       <= 1'b0;
         r_Cin     <= 1'b0;
         r_doLo    <= '0;
         r_carryLo <= 1'b0;
         r_zeroLo  <= 1'b0;
         r_outDO   <= '0;
         r_outC    <= 1'b0;
         r_outV    <= 1'b0;
         r_outN    <= 1'b0;
         r_outZ    <= 1'b0;
      end else begin
         if (w_accept) begin
            r_opA <= in_opA;
            r_opB <= in_opB;
            r_S   <= in_S;
            r_M   <= in_M;
            r_Cin <= in_Cin;
         end
         if (r_state == ST_LO) begin
            r_doLo    <= w_coreDO;
            r_carryLo <= w_coreC;
            r_zeroLo  <= w_coreZ;
         end
         // Visible results only ever change on the HI -> DONE edge
         if (r_state == ST_HI) begin
            r_outDO <= {w_coreDO, r_doLo};
            r_outN  <= w_coreDO[N-1];
            r_outZ  <= r_zeroLo & w_coreZ;
            r_outC  <= r_M & w_coreC;
            r_outV  <= r_M & w_coreV;
         end
      end
   end

   assign out_DO = r_outDO;
   assign out_C  = r_outC;
   assign out_V  = r_outV;
   assign out_N  = r_outN;
   assign out_Z  = r_outZ;

endmodule

// File: tb/tb_alu_wide_seq.sv
// Directed bench for alu_wide_seq: hand-computed 64-bit results, latency,
// back-pressure hold and mid-operation reset.
module tb_alu_wide_seq;
   import alu_wide_seq_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_opA;
   logic [63:0] in_opB;
   logic [3:0]  in_S;
   logic        in_M;
   logic        in_Cin;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_DO;
   logic        out_C;
   logic        out_V;
   logic        out_N;
   logic        out_Z;

   int checks = 0;
   int errors = 0;

   alu_wide_seq #(.N(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_opA    (in_opA),
      .in_opB    (in_opB),
      .in_S      (in_S),
      .in_M      (in_M),
      .in_Cin    (in_Cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_DO    (out_DO),
      .out_C     (out_C),
      .out_V     (out_V),
      .out_N     (out_N),
      .out_Z     (out_Z)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkValue(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Present one request for a single edge, then scramble the inputs
   task automatic acceptOp(input logic [63:0] a, input logic [63:0] b,
                           input logic [3:0] s, input logic m, input logic cin);
      checkValue("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
      in_valid = 1'b1;
      in_opA   = a;
      in_opB   = b;
      in_S     = s;
      in_M     = m;
      in_Cin   = cin;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_opA   = {$urandom, $urandom};
      in_opB   = {$urandom, $urandom};
      in_S     = 4'($urandom);
      in_M     = 1'($urandom);
      in_Cin   = 1'($urandom);
   endtask

   task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b,
                                input logic [3:0] s, input logic m, input logic cin);
      acceptOp(a, b, s, m, cin);
      checkValue("in_ready_busy", {63'd0, in_ready}, 64'd0);
      checkValue("out_valid_edge1", {63'd0, out_valid}, 64'd0);
      @(posedge clk); #1;
      checkValue("out_valid_edge2", {63'd0, out_valid}, 64'd0);
      @(posedge clk); #1;
      checkValue("out_valid_edge3", {63'd0, out_valid}, 64'd1);
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] expDO,
                              input logic c, input logic v, input logic n, input logic z);
      checkValue({tag, "_DO"}, out_DO, expDO);
      checkValue({tag, "_CVNZ"}, {60'd0, out_C, out_V, out_N, out_Z}, {60'd0, c, v, n, z});
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checkValue("out_valid_after_hs", {63'd0, out_valid}, 64'd0);
      checkValue("in_ready_after_hs", {63'd0, in_ready}, 64'd1);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_opA    = '0;
      in_opB    = '0;
      in_S      = '0;
      in_M      = 1'b0;
      in_Cin    = 1'b0;
      out_ready = 1'b0;
      #12;
      checkValue("rst_out_valid", {63'd0, out_valid}, 64'd0);
      checkValue("rst_out_DO", out_DO, 64'd0);
      checkValue("rst_flags", {60'd0, out_C, out_V, out_N, out_Z}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      checkValue("rst_in_ready", {63'd0, in_ready}, 64'd1);

      // out_ready while idle must not disturb anything
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checkValue("idle_out_ready_ignored", {63'd0, out_valid}, 64'd0);

      applyStimulus(64'h0000_0000_FFFF_FFFF, 64'h1, S_ADD, M_ADD, 1'b0);
      checkOutput("add_carry_chain", 64'h0000_0001_0000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
      handshake();

      applyStimulus(64'hF000_0000_0000_0001, 64'hF000_0000_0000_0001, S_ADD, M_ADD, 1'b0);
      checkOutput("add_carry_out", 64'hE000_0000_0000_0002, 1'b1, 1'b0, 1'b1, 1'b0);
      handshake();

      applyStimulus(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, S_ADD, M_ADD, 1'b0);
      checkOutput("add_overflow", 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b1, 1'b0);
      handshake();

      applyStimulus(64'h0000_0001_0000_0000, 64'h1, S_SUB, M_SUB, 1'b1);
      checkOutput("sub_borrow_chain", 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0);
      handshake();

      // Back-pressure: result holds while extra requests are offered and ignored
      applyStimulus(64'h0, 64'h0, S_ADD, M_ADD, 1'b0);
      checkOutput("add_zero", 64'h0, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_opA   = 64'h1234_5678_9ABC_DEF0;
         in_opB   = 64'h1111_1111_1111_1111;
         @(posedge clk); #1;
         checkValue("hold_out_valid", {63'd0, out_valid}, 64'd1);
         checkValue("hold_out_DO", out_DO, 64'h0);
         checkValue("hold_out_Z", {63'd0, out_Z}, 64'd1);
         checkValue("hold_in_ready", {63'd0, in_ready}, 64'd0);
      end
      in_valid = 1'b0;
      handshake();

      applyStimulus(64'hFFFF_0000_0000_000F, 64'h0F0F_0000_0000_0001, S_AND, M_AND, 1'b1);
      checkOutput("and_logic", 64'h0F0F_0000_0000_0001, 1'b0, 1'b0, 1'b0, 1'b0);
      handshake();

      // Reset asserted while the high half is being computed
      acceptOp(64'h0000_0000_FFFF_FFFF, 64'h1, S_ADD, M_ADD, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      checkValue("abort_out_valid", {63'd0, out_valid}, 64'd0);
      checkValue("abort_out_DO", out_DO, 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      checkValue("abort_in_ready", {63'd0, in_ready}, 64'd1);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checkValue("abort_no_result", {63'd0, out_valid}, 64'd0);
      end

      applyStimulus(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, S_ADD, M_ADD, 1'b1);
      checkOutput("post_reset_add", 64'h1234_5678_9ABC_DF01, 1'b0, 1'b0, 1'b0, 1'b0);
      handshake();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
